// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and source indices for the common-data-bus arbiter.
package cdb_arbiter_pkg;

  localparam int tagWidth    = 5;
  localparam int dataWidth   = 32;
  localparam int addrWidth   = 32;
  localparam int cdbSrcWidth = 2;

  localparam int srcALU = 0;
  localparam int srcLSB = 1;
  localparam int srcBRU = 2;

  // Round-robin successor of a source index, wrapping at n.
  function automatic logic [cdbSrcWidth-1:0] wrap_inc(input logic [cdbSrcWidth-1:0] i,
                                                      input int n);
    return (int'(i) == n - 1) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side handshake and CDB broadcast bundle of the arbiter.
interface cdb_arbiter_if import cdb_arbiter_pkg::*; #(
  parameter int N_SRC  = 3,
  parameter int TAG_W  = tagWidth,
  parameter int DATA_W = dataWidth,
  parameter int ADDR_W = addrWidth
) ();

  logic                      rdy;
  logic                      flush;
  logic [N_SRC-1:0]          src_valid;
  logic [N_SRC-1:0]          src_ready;
  logic [N_SRC*TAG_W-1:0]    src_tag;
  logic [N_SRC*DATA_W-1:0]   src_data;
  logic [N_SRC-1:0]          src_jump;
  logic [N_SRC*ADDR_W-1:0]   src_pc;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic                      cdb_jump;
  logic [ADDR_W-1:0]         cdb_pc;
  logic [cdbSrcWidth-1:0]    cdb_src;

  modport slave (
    input  rdy, flush, src_valid, src_tag, src_data, src_jump, src_pc,
    output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_jump, cdb_pc, cdb_src
  );

  modport master (
    output rdy, flush, src_valid, src_tag, src_data, src_jump, src_pc,
    input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_jump, cdb_pc, cdb_src
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// N-way round-robin picker: first request at or after ptr, wrapping.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int j;

  // Scan from ptr upward; the first hit wins and masks the rest.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one-entry buffer per producer, round-robin
// grant onto a registered broadcast bus, flush discards everything held.
module cdb_arbiter import cdb_arbiter_pkg::*; #(
  parameter int N_SRC  = 3,
  parameter int TAG_W  = tagWidth,
  parameter int DATA_W = dataWidth,
  parameter int ADDR_W = addrWidth
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);

  logic [N_SRC-1:0]       vld_p0;
  logic [TAG_W-1:0]       tag_p0  [N_SRC];
  logic [DATA_W-1:0]      data_p0 [N_SRC];
  logic                   jump_p0 [N_SRC];
  logic [ADDR_W-1:0]      pc_p0   [N_SRC];
  logic [cdbSrcWidth-1:0] ptr;

  logic                   vld_p1;
  logic [TAG_W-1:0]       tag_p1;
  logic [DATA_W-1:0]      data_p1;
  logic                   jump_p1;
  logic [ADDR_W-1:0]      pc_p1;
  logic [cdbSrcWidth-1:0] src_p1;

  logic [N_SRC-1:0]       grant;
  logic [N_SRC-1:0]       ready;
  logic [N_SRC-1:0]       accept;
  logic [cdbSrcWidth-1:0] gnt_idx;
  logic                   gnt_any;
  logic [TAG_W-1:0]       sel_tag;
  logic [DATA_W-1:0]      sel_data;
  logic                   sel_jump;
  logic [ADDR_W-1:0]      sel_pc;

  // Grant depends only on registered state, so ready never looks at valid.
  rr_pick #(.N(N_SRC), .IDX_W(cdbSrcWidth)) u_pick (
    .req   (vld_p0),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign ready         = {N_SRC{bus.rdy & ~bus.flush}} & (~vld_p0 | grant);
  assign accept        = bus.src_valid & ready;
  assign bus.src_ready = ready;

  // One-hot payload mux for the granted source.
  always_comb begin
    sel_tag  = '0;
    sel_data = '0;
    sel_jump = 1'b0;
    sel_pc   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant[i]) begin
        sel_tag  = sel_tag  | tag_p0[i];
        sel_data = sel_data | data_p0[i];
        sel_jump = sel_jump | jump_p0[i];
        sel_pc   = sel_pc   | pc_p0[i];
      end
    end
  end

  // ---- stage p0: per-source buffer occupancy and round-robin pointer ----
  // Occupancy/pointer update; a grant and a refill on the same source keep it full.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= '0;
      ptr    <= '0;
    end else if (bus.rdy) begin
      if (bus.flush) begin
        vld_p0 <= '0;
      end else begin
        vld_p0 <= (vld_p0 & ~grant) | accept;
        if (gnt_any) ptr <= wrap_inc(gnt_idx, N_SRC);
      end
    end
  end

  // Payload capture on accept; accept already excludes stall and flush.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (accept[i]) begin
        tag_p0[i]  <= bus.src_tag[i*TAG_W +: TAG_W];
        data_p0[i] <= bus.src_data[i*DATA_W +: DATA_W];
        jump_p0[i] <= bus.src_jump[i];
        pc_p0[i]   <= bus.src_pc[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // ---- stage p1: registered CDB broadcast ----
  // Broadcast register; valid is a single-cycle pulse, fields hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      tag_p1  <= '0;
      data_p1 <= '0;
      jump_p1 <= 1'b0;
      pc_p1   <= '0;
      src_p1  <= '0;
    end else if (bus.rdy) begin
      if (bus.flush) begin
        vld_p1 <= 1'b0;
      end else if (gnt_any) begin
        vld_p1  <= 1'b1;
        tag_p1  <= sel_tag;
        data_p1 <= sel_data;
        jump_p1 <= sel_jump;
        pc_p1   <= sel_pc;
        src_p1  <= gnt_idx;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.cdb_valid = vld_p1;
  assign bus.cdb_tag   = tag_p1;
  assign bus.cdb_data  = data_p1;
  assign bus.cdb_jump  = jump_p1;
  assign bus.cdb_pc    = pc_p1;
  assign bus.cdb_src   = src_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter plus hand-written sequences.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] v;
    logic [4:0] t0, t1, t2;
    logic       fl;
    logic       rd;
    logic [2:0] exp_rdy;
    logic       exp_cv;
    logic [4:0] exp_tag;
    logic [1:0] exp_src;
  } vec_t;

  vec_t tbl [30];

  function automatic vec_t mk(logic [2:0] v, logic [4:0] t0, logic [4:0] t1, logic [4:0] t2,
                              logic fl, logic rd, logic [2:0] erdy, logic ecv,
                              logic [4:0] etag, logic [1:0] esrc);
    vec_t r;
    r.v = v; r.t0 = t0; r.t1 = t1; r.t2 = t2; r.fl = fl; r.rd = rd;
    r.exp_rdy = erdy; r.exp_cv = ecv; r.exp_tag = etag; r.exp_src = esrc;
    return r;
  endfunction

  // Payload model: data encodes source and tag, only the BRU redirects.
  function automatic logic [31:0] dat(int s, logic [4:0] t);
    return {8'(s + 1), 19'd0, t};
  endfunction

  function automatic logic [31:0] pcf(logic [4:0] t);
    return 32'h100 + {27'd0, t};
  endfunction

  task automatic chk(string name, int row, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s row=%0d got=%h want=%h", name, row, got, want);
    end
  endtask

  task automatic drive(logic [2:0] v, logic [4:0] t0, logic [4:0] t1, logic [4:0] t2,
                       logic fl, logic rd);
    bus.src_valid = v;
    bus.src_tag   = {t2, t1, t0};
    bus.src_data  = {dat(2, t2), dat(1, t1), dat(0, t0)};
    bus.src_jump  = 3'b100;
    bus.src_pc    = {pcf(t2), pcf(t1), pcf(t0)};
    bus.flush     = fl;
    bus.rdy       = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog row=0 got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;

    tbl[0]  = mk(3'b001,  1, 0, 0, 0, 1, 3'b111, 0,  0, 0);
    tbl[1]  = mk(3'b000,  0, 0, 0, 0, 1, 3'b111, 1,  1, 0);
    tbl[2]  = mk(3'b111,  2, 3, 4, 0, 1, 3'b111, 0,  0, 0);
    tbl[3]  = mk(3'b000,  0, 0, 0, 0, 1, 3'b010, 1,  3, 1);
    tbl[4]  = mk(3'b000,  0, 0, 0, 0, 1, 3'b110, 1,  4, 2);
    tbl[5]  = mk(3'b000,  0, 0, 0, 0, 1, 3'b111, 1,  2, 0);
    tbl[6]  = mk(3'b000,  0, 0, 0, 0, 1, 3'b111, 0,  0, 0);
    tbl[7]  = mk(3'b101,  5, 0, 6, 0, 1, 3'b111, 0,  0, 0);
    tbl[8]  = mk(3'b000,  0, 0, 0, 0, 1, 3'b110, 1,  6, 2);
    tbl[9]  = mk(3'b000,  0, 0, 0, 0, 1, 3'b111, 1,  5, 0);
    tbl[10] = mk(3'b001,  1, 0, 0, 0, 1, 3'b111, 0,  0, 0);
    tbl[11] = mk(3'b001,  2, 0, 0, 0, 1, 3'b111, 1,  1, 0);
    tbl[12] = mk(3'b001,  3, 0, 0, 0, 1, 3'b111, 1,  2, 0);
    tbl[13] = mk(3'b000,  0, 0, 0, 0, 1, 3'b111, 1,  3, 0);
    tbl[14] = mk(3'b000,  0, 0, 0, 0, 1, 3'b111, 0,  0, 0);
    tbl[15] = mk(3'b110,  0, 7, 9, 0, 1, 3'b111, 0,  0, 0);
    tbl[16] = mk(3'b001, 10, 0, 0, 1, 1, 3'b000, 0,  0, 0);
    tbl[17] = mk(3'b000,  0, 0, 0, 0, 1, 3'b111, 0,  0, 0);
    tbl[18] = mk(3'b000,  0, 0, 0, 0, 1, 3'b111, 0,  0, 0);
    tbl[19] = mk(3'b011, 11, 12, 0, 0, 1, 3'b111, 0,  0, 0);
    tbl[20] = mk(3'b000,  0, 0, 0, 0, 1, 3'b110, 1, 12, 1);
    tbl[21] = mk(3'b000,  0, 0, 0, 1, 1, 3'b000, 0,  0, 0);
    tbl[22] = mk(3'b000,  0, 0, 0, 0, 1, 3'b111, 0,  0, 0);
    tbl[23] = mk(3'b011, 13, 14, 0, 0, 1, 3'b111, 0,  0, 0);
    tbl[24] = mk(3'b000,  0, 0, 0, 0, 1, 3'b101, 1, 13, 0);
    tbl[25] = mk(3'b001, 15, 0, 0, 0, 0, 3'b000, 1, 13, 0);
    tbl[26] = mk(3'b001, 15, 0, 0, 0, 0, 3'b000, 1, 13, 0);
    tbl[27] = mk(3'b001, 15, 0, 0, 0, 0, 3'b000, 1, 13, 0);
    tbl[28] = mk(3'b000,  0, 0, 0, 0, 1, 3'b111, 1, 14, 1);
    tbl[29] = mk(3'b000,  0, 0, 0, 0, 1, 3'b111, 0,  0, 0);

    // Reset with every producer presenting: nothing may be captured.
    rst = 1'b1;
    drive(3'b111, 20, 21, 22, 0, 1);
    step();
    step();
    chk("rst_cdb_valid", -1, 32'(bus.cdb_valid), 32'd0);
    chk("rst_cdb_tag",   -1, 32'(bus.cdb_tag),   32'd0);
    chk("rst_cdb_data",  -1, bus.cdb_data,       32'd0);
    chk("rst_cdb_jump",  -1, 32'(bus.cdb_jump),  32'd0);
    chk("rst_cdb_pc",    -1, bus.cdb_pc,         32'd0);
    chk("rst_cdb_src",   -1, 32'(bus.cdb_src),   32'd0);
    rst = 1'b0;
    drive(3'b000, 0, 0, 0, 0, 1);
    #1;
    chk("rst_ready", -1, 32'(bus.src_ready), 32'h7);
    step();
    chk("rst_no_accept", -1, 32'(bus.cdb_valid), 32'd0);

    // Table: ready before the edge, broadcast after it.
    for (int r = 0; r < 30; r++) begin
      drive(tbl[r].v, tbl[r].t0, tbl[r].t1, tbl[r].t2, tbl[r].fl, tbl[r].rd);
      #1;
      chk("src_ready", r, 32'(bus.src_ready), 32'(tbl[r].exp_rdy));
      step();
      chk("cdb_valid", r, 32'(bus.cdb_valid), 32'(tbl[r].exp_cv));
      if (tbl[r].exp_cv) begin
        chk("cdb_tag",  r, 32'(bus.cdb_tag),  32'(tbl[r].exp_tag));
        chk("cdb_src",  r, 32'(bus.cdb_src),  32'(tbl[r].exp_src));
        chk("cdb_data", r, bus.cdb_data, dat(int'(tbl[r].exp_src), tbl[r].exp_tag));
        chk("cdb_jump", r, 32'(bus.cdb_jump), (tbl[r].exp_src == 2'd2) ? 32'd1 : 32'd0);
        if (tbl[r].exp_src == 2'd2)
          chk("cdb_pc", r, bus.cdb_pc, pcf(tbl[r].exp_tag));
      end
    end

    // Single ALU result with a literal payload; pointer left empty-handed at 2.
    drive(3'b000, 0, 0, 0, 0, 1);
    bus.src_valid = 3'b001;
    bus.src_tag   = {5'd0, 5'd0, 5'd5};
    bus.src_data  = {32'd0, 32'd0, 32'h1234};
    bus.src_jump  = 3'b000;
    step();
    bus.src_valid = 3'b000;
    step();
    chk("alu_valid", 100, 32'(bus.cdb_valid), 32'd1);
    chk("alu_tag",   100, 32'(bus.cdb_tag),   32'd5);
    chk("alu_data",  100, bus.cdb_data,       32'h1234);
    chk("alu_src",   100, 32'(bus.cdb_src),   32'd0);
    chk("alu_jump",  100, 32'(bus.cdb_jump),  32'd0);
    step();
    chk("alu_pulse", 101, 32'(bus.cdb_valid), 32'd0);

    // Pointer now at 1: LSB must win over ALU when both are held.
    drive(3'b011, 20, 21, 0, 0, 1);
    step();
    drive(3'b000, 0, 0, 0, 0, 1);
    step();
    chk("ptr1_src", 102, 32'(bus.cdb_src), 32'd1);
    chk("ptr1_tag", 102, 32'(bus.cdb_tag), 32'd21);
    step();
    chk("ptr1_next_src", 103, 32'(bus.cdb_src), 32'd0);
    chk("ptr1_next_tag", 103, 32'(bus.cdb_tag), 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
